// File: rtl/score_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : score_pkg                                                         |
// | Purpose : Shared types and constants for the Pong score/digit renderer:    |
// |           game state encoding, 7-segment bit indices, default window       |
// |           geometry and the digit-to-segment font function.                 |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package score_pkg;

  // Game state encoding
  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  // Segment bit positions in the font word
  localparam int c_seg_top = 0;
  localparam int c_seg_ul  = 1;
  localparam int c_seg_ur  = 2;
  localparam int c_seg_mid = 3;
  localparam int c_seg_ll  = 4;
  localparam int c_seg_lr  = 5;
  localparam int c_seg_bot = 6;

  // Default digit window geometry (pixels)
  localparam int c_def_left_x0  = 256;
  localparam int c_def_right_x0 = 368;
  localparam int c_def_y0       = 32;
  localparam int c_def_seg_len  = 16;
  localparam int c_def_seg_w    = 4;

  // Decimal digit to lit-segment pattern; codes 10..15 draw nothing.
  function automatic logic [6:0] seg_font(input logic [3:0] digit);
    logic [6:0] v;
    case (digit)
      4'd0:    v = 7'h77;
      4'd1:    v = 7'h24;
      4'd2:    v = 7'h5D;
      4'd3:    v = 7'h6D;
      4'd4:    v = 7'h2E;
      4'd5:    v = 7'h6B;
      4'd6:    v = 7'h7B;
      4'd7:    v = 7'h25;
      4'd8:    v = 7'h7F;
      4'd9:    v = 7'h6F;
      default: v = 7'h00;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_ctrl_font_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : font_rom                                                          |
// | Purpose : 16-entry x 7-bit 7-segment glyph ROM with a registered address;  |
// |           data is valid one cycle after the address is presented.         |
// | Ports   : i_clk   - clock                                                  |
// |           i_rst   - synchronous active-high reset (clears address reg)     |
// |           i_addr  - digit code (4 bits)                                    |
// |           o_data  - segment pattern for the registered address (7 bits)    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module font_rom
  import score_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_addr,
  output logic [6:0] o_data
);

  logic [3:0] r_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
    end else begin
      r_addr <= i_addr;
    end
  end

  assign o_data = seg_font(r_addr);

endmodule
`default_nettype wire

// File: rtl/score_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : score_ctrl                                                        |
// | Purpose : Pong score keeper and score-digit renderer. Counts points,       |
// |           detects the winner, and draws both score digits into the pixel   |
// |           stream by time-sharing one font_rom between the two windows.     |
// | Ports   : i_clk, i_rst            - clock, synchronous active-high reset   |
// |           i_pix_x, i_pix_y        - current pixel coordinate               |
// |           i_video_on              - pixel is visible                       |
// |           i_frame_tick            - one pulse per frame                    |
// |           i_point_left/right      - point scored pulses                    |
// |           i_new_game              - restart pulse                          |
// |           o_score_pix             - pixel on a lit segment (2-cycle lat.)  |
// |           o_score_left/right      - current scores                         |
// |           o_game_over, o_winner   - game end flag, 0 = left, 1 = right     |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module score_ctrl
  import score_pkg::*;
#(
  parameter int H_BITS     = 10,
  parameter int V_BITS     = 10,
  parameter int LEFT_X0    = c_def_left_x0,
  parameter int RIGHT_X0   = c_def_right_x0,
  parameter int Y0         = c_def_y0,
  parameter int SEG_LEN    = c_def_seg_len,
  parameter int SEG_W      = c_def_seg_w,
  parameter int WIN_SCORE  = 9,
  parameter int BLINK_LOG2 = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [H_BITS-1:0] i_pix_x,
  input  logic [V_BITS-1:0] i_pix_y,
  input  logic              i_video_on,
  input  logic              i_frame_tick,
  input  logic              i_point_left,
  input  logic              i_point_right,
  input  logic              i_new_game,
  output logic              o_score_pix,
  output logic [3:0]        o_score_left,
  output logic [3:0]        o_score_right,
  output logic              o_game_over,
  output logic              o_winner
);

  localparam int LX_W = $clog2(SEG_LEN);
  localparam int LY_W = $clog2(2 * SEG_LEN);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [3:0]          r_score_left;
  logic [3:0]          r_score_right;
  logic                r_winner;
  logic [BLINK_LOG2:0] r_blink;
  logic                r_hit;
  logic                r_side;       // 0 = left window, 1 = right window
  logic [LX_W-1:0]     r_lx;
  logic [LY_W-1:0]     r_ly;
  logic                r_score_pix;

  // ---------------------------------------------------------------------------
  // Game FSM next-state
  // ---------------------------------------------------------------------------
  state_t              w_state_nxt;
  logic [3:0]          w_left_nxt;
  logic [3:0]          w_right_nxt;
  logic                w_winner_nxt;
  logic [BLINK_LOG2:0] w_blink_nxt;
  logic [3:0]          w_left_inc;
  logic [3:0]          w_right_inc;
  logic                w_left_wins;
  logic                w_right_wins;

  assign w_left_inc   = r_score_left  + {3'b000, i_point_left};
  assign w_right_inc  = r_score_right + {3'b000, i_point_right};
  assign w_left_wins  = (w_left_inc  == 4'(WIN_SCORE));
  assign w_right_wins = (w_right_inc == 4'(WIN_SCORE));

  always_comb begin
    w_state_nxt  = r_state;
    w_left_nxt   = r_score_left;
    w_right_nxt  = r_score_right;
    w_winner_nxt = r_winner;
    w_blink_nxt  = r_blink;
    case (r_state)
      ST_PLAY: begin
        if (i_new_game) begin
          w_left_nxt  = '0;
          w_right_nxt = '0;
        end else begin
          w_left_nxt  = w_left_inc;
          w_right_nxt = w_right_inc;
          if (w_left_wins || w_right_wins) begin
            w_state_nxt  = ST_OVER;
            // A simultaneous win goes to the left player.
            w_winner_nxt = ~w_left_wins;
          end
        end
      end
      ST_OVER: begin
        if (i_new_game) begin
          w_state_nxt  = ST_PLAY;
          w_left_nxt   = '0;
          w_right_nxt  = '0;
          w_winner_nxt = 1'b0;
        end else if (i_frame_tick) begin
          w_blink_nxt = r_blink + 1'b1;
        end
      end
      default: w_state_nxt = ST_PLAY;
    endcase
    // The blink phase always restarts from zero for the next game.
    if (w_state_nxt != ST_OVER) begin
      w_blink_nxt = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel stage S0: window decode and ROM address
  // ---------------------------------------------------------------------------
  logic              w_in_rows;
  logic              w_in_left;
  logic              w_in_right;
  logic [H_BITS-1:0] w_x0;
  logic [LX_W-1:0]   w_lx;
  logic [LY_W-1:0]   w_ly;
  logic [3:0]        w_rom_addr;
  logic [6:0]        w_rom_data;

  assign w_in_rows  = (i_pix_y >= V_BITS'(Y0)) &&
                      (i_pix_y <  V_BITS'(Y0 + 2 * SEG_LEN));
  assign w_in_left  = w_in_rows && (i_pix_x >= H_BITS'(LEFT_X0)) &&
                      (i_pix_x < H_BITS'(LEFT_X0 + SEG_LEN));
  assign w_in_right = w_in_rows && (i_pix_x >= H_BITS'(RIGHT_X0)) &&
                      (i_pix_x < H_BITS'(RIGHT_X0 + SEG_LEN));

  assign w_x0       = w_in_right ? H_BITS'(RIGHT_X0) : H_BITS'(LEFT_X0);
  // Offsets are only meaningful inside a window, where they fit the narrow width.
  assign w_lx       = LX_W'(i_pix_x - w_x0);
  assign w_ly       = LY_W'(i_pix_y - V_BITS'(Y0));
  assign w_rom_addr = w_in_right ? r_score_right : r_score_left;

  font_rom u_font_rom (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  // ---------------------------------------------------------------------------
  // Pixel stage S1: segment geometry against the ROM glyph
  // ---------------------------------------------------------------------------
  logic       w_top;
  logic       w_mid;
  logic       w_bot;
  logic       w_lcol;
  logic       w_rcol;
  logic       w_upper;
  logic [6:0] w_seg_mask;
  logic       w_blank;
  logic       w_pix_nxt;

  assign w_top   = (r_ly <  LY_W'(SEG_W));
  assign w_mid   = (r_ly >= LY_W'(SEG_LEN - SEG_W / 2)) &&
                   (r_ly <  LY_W'(SEG_LEN + SEG_W / 2));
  assign w_bot   = (r_ly >= LY_W'(2 * SEG_LEN - SEG_W));
  assign w_lcol  = (r_lx <  LX_W'(SEG_W));
  assign w_rcol  = (r_lx >= LX_W'(SEG_LEN - SEG_W));
  assign w_upper = (r_ly <  LY_W'(SEG_LEN));

  always_comb begin
    w_seg_mask            = '0;
    w_seg_mask[c_seg_top] = w_top;
    w_seg_mask[c_seg_ul]  = w_lcol &  w_upper;
    w_seg_mask[c_seg_ur]  = w_rcol &  w_upper;
    w_seg_mask[c_seg_mid] = w_mid;
    w_seg_mask[c_seg_ll]  = w_lcol & ~w_upper;
    w_seg_mask[c_seg_lr]  = w_rcol & ~w_upper;
    w_seg_mask[c_seg_bot] = w_bot;
  end

  // The winner's digit is hidden during the upper half of the blink period.
  assign w_blank   = (r_state == ST_OVER) && (r_side == r_winner) &&
                     r_blink[BLINK_LOG2];
  assign w_pix_nxt = r_hit && (|(w_rom_data & w_seg_mask)) && !w_blank;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_PLAY;
      r_score_left  <= '0;
      r_score_right <= '0;
      r_winner      <= 1'b0;
      r_blink       <= '0;
      r_hit         <= 1'b0;
      r_side        <= 1'b0;
      r_lx          <= '0;
      r_ly          <= '0;
      r_score_pix   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_score_left  <= w_left_nxt;
      r_score_right <= w_right_nxt;
      r_winner      <= w_winner_nxt;
      r_blink       <= w_blink_nxt;
      r_hit         <= (w_in_left | w_in_right) & i_video_on;
      r_side        <= w_in_right;
      r_lx          <= w_lx;
      r_ly          <= w_ly;
      r_score_pix   <= w_pix_nxt;
    end
  end

  assign o_score_pix   = r_score_pix;
  assign o_score_left  = r_score_left;
  assign o_score_right = r_score_right;
  assign o_game_over   = (r_state == ST_OVER);
  assign o_winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_score_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_score_ctrl                                                     |
// | Purpose : Self-checking bench for score_ctrl. Score/state outputs are      |
// |           compared against constants; pixel outputs go through a           |
// |           cycle-stamped scoreboard fed by a small reference model.         |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_score_ctrl;

  localparam int LEFT_X0  = 256;
  localparam int RIGHT_X0 = 368;
  localparam int Y0       = 32;
  localparam int SEG_LEN  = 16;
  localparam int SEG_W    = 4;
  localparam int WIN      = 9;

  // Glyphs: bit0 top, 1 UL, 2 UR, 3 mid, 4 LL, 5 LR, 6 bottom
  localparam logic [6:0] FONT [10] = '{7'h77, 7'h24, 7'h5D, 7'h6D, 7'h2E,
                                       7'h6B, 7'h7B, 7'h25, 7'h7F, 7'h6F};

  logic       clk;
  logic       rst;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       frame_tick;
  logic       point_left;
  logic       point_right;
  logic       new_game;
  logic       score_pix;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner;

  score_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pix_x       (pix_x),
    .i_pix_y       (pix_y),
    .i_video_on    (video_on),
    .i_frame_tick  (frame_tick),
    .i_point_left  (point_left),
    .i_point_right (point_right),
    .i_new_game    (new_game),
    .o_score_pix   (score_pix),
    .o_score_left  (score_left),
    .o_score_right (score_right),
    .o_game_over   (game_over),
    .o_winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference game state
  int m_left, m_right, m_blink;
  bit m_over, m_winner;

  typedef struct {
    int    due;
    int    exp;
    string tag;
  } sb_t;
  sb_t sbq[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit in_win(input int x, input int y, input int x0);
    return (x >= x0) && (x < x0 + SEG_LEN) && (y >= Y0) && (y < Y0 + 2 * SEG_LEN);
  endfunction

  function automatic bit model_lit(input int x, input int y, input bit v,
                                   input int sl, input int sr);
    bit il, ir;
    int lx, ly;
    logic [6:0] f;
    logic [6:0] m;
    il = in_win(x, y, LEFT_X0);
    ir = in_win(x, y, RIGHT_X0);
    if (!(il || ir) || !v) return 1'b0;
    lx = x - (ir ? RIGHT_X0 : LEFT_X0);
    ly = y - Y0;
    f  = FONT[ir ? sr : sl];
    m[0] = ly < SEG_W;
    m[1] = (lx < SEG_W) && (ly < SEG_LEN);
    m[2] = (lx >= SEG_LEN - SEG_W) && (ly < SEG_LEN);
    m[3] = (ly >= SEG_LEN - SEG_W / 2) && (ly < SEG_LEN + SEG_W / 2);
    m[4] = (lx < SEG_W) && (ly >= SEG_LEN);
    m[5] = (lx >= SEG_LEN - SEG_W) && (ly >= SEG_LEN);
    m[6] = ly >= 2 * SEG_LEN - SEG_W;
    return |(f & m);
  endfunction

  task automatic model_update();
    int l, r;
    if (rst) begin
      m_left = 0; m_right = 0; m_over = 0; m_winner = 0; m_blink = 0;
    end else if (!m_over) begin
      if (new_game) begin
        m_left = 0; m_right = 0;
      end else begin
        l = m_left + int'(point_left);
        r = m_right + int'(point_right);
        m_left = l; m_right = r;
        if (l == WIN || r == WIN) begin
          m_over   = 1;
          m_winner = (l == WIN) ? 1'b0 : 1'b1;
        end
      end
    end else begin
      if (new_game) begin
        m_left = 0; m_right = 0; m_over = 0; m_winner = 0; m_blink = 0;
      end else if (frame_tick) begin
        m_blink = (m_blink + 1) % 64;
      end
    end
  endtask

  // One clock. want: -2 = pixel not tracked, -1 = model expectation,
  // 0/1 = fixed expectation (blanking still applied by the model).
  task automatic step(input int want, input string tag);
    bit lit, side, blank;
    side = in_win(int'(pix_x), int'(pix_y), RIGHT_X0);
    lit  = model_lit(int'(pix_x), int'(pix_y), video_on, m_left, m_right);
    if (want >= 0) lit = (want != 0);
    @(posedge clk);
    model_update();
    cyc++;
    if (want != -2) begin
      // Blanking is evaluated with state as it stands after this edge.
      blank = m_over && (side == m_winner) && (m_blink >= 32);
      sbq.push_back('{due: cyc + 1, exp: int'(lit && !blank), tag: tag});
    end
    @(negedge clk);
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      sb_t e;
      e = sbq.pop_front();
      check(e.tag, int'(score_pix), e.exp);
    end
  endtask

  task automatic set_pix(input int x, input int y, input bit v);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; pix_x = '0; pix_y = '0; video_on = 0; frame_tick = 0;
    point_left = 0; point_right = 0; new_game = 0;
    @(negedge clk);
    step(-2, "rst");
    step(-2, "rst");
    rst = 0;
    step(-2, "idle");

    // Reset state
    check("rst_left", int'(score_left), 0);
    check("rst_right", int'(score_right), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_pix", int'(score_pix), 0);

    // Pixels just outside both windows
    begin
      int ox[6] = '{0, LEFT_X0 - 1, LEFT_X0 + SEG_LEN, RIGHT_X0 + 5, RIGHT_X0 + 5, 639};
      int oy[6] = '{0, Y0 + 5, Y0 + 5, Y0 - 1, Y0 + 2 * SEG_LEN, 479};
      for (int i = 0; i < 6; i++) begin
        set_pix(ox[i], oy[i], 1);
        step(0, "outside_pix");
      end
    end
    set_pix(0, 0, 0);

    // Three left points then one right point
    for (int i = 0; i < 3; i++) begin
      point_left = 1;
      check("left_before", int'(score_left), i);
      step(-2, "pt");
      point_left = 0;
      check("left_after", int'(score_left), i + 1);
    end
    point_right = 1;
    step(-2, "pt");
    point_right = 0;
    check("right_1", int'(score_right), 1);
    check("left_3", int'(score_left), 3);

    // new_game in PLAY, then left = 1
    new_game = 1;
    step(-2, "ng");
    new_game = 0;
    check("ng_left", int'(score_left), 0);
    check("ng_right", int'(score_right), 0);
    point_left = 1;
    step(-2, "pt");
    point_left = 0;
    check("left_1", int'(score_left), 1);

    set_pix(LEFT_X0 + 14, Y0 + 5, 1);
    step(1, "digit1_ur");
    set_pix(LEFT_X0 + 1, Y0 + 1, 1);
    step(0, "digit1_top");
    set_pix(LEFT_X0 + 14, Y0 + 5, 0);
    step(0, "video_off");
    for (int y = Y0; y < Y0 + 2 * SEG_LEN; y += 3) begin
      set_pix(LEFT_X0 + 2, y, 1);
      step(-1, "sweep_l_lo");
      set_pix(RIGHT_X0 + 13, y, 1);
      step(-1, "sweep_r_hi");
      set_pix(LEFT_X0 + 7, y, 1);
      step(-1, "sweep_l_mid");
    end
    set_pix(0, 0, 0);
    step(-2, "flush");
    step(-2, "flush");

    // Both to 8, then a simultaneous winning point
    new_game = 1;
    step(-2, "ng");
    new_game = 0;
    for (int i = 0; i < 8; i++) begin
      point_left = 1; point_right = 1;
      step(-2, "pt");
    end
    check("both_8_left", int'(score_left), 8);
    check("both_8_right", int'(score_right), 8);
    check("both_8_over", int'(game_over), 0);
    step(-2, "pt");
    check("tie_left", int'(score_left), 9);
    check("tie_right", int'(score_right), 9);
    check("tie_over", int'(game_over), 1);
    check("tie_winner", int'(winner), 0);
    step(-2, "pt");
    step(-2, "pt");
    point_left = 0; point_right = 0;
    check("over_hold_left", int'(score_left), 9);
    check("over_hold_right", int'(score_right), 9);

    // new_game beats a simultaneous point in OVER
    new_game = 1; point_right = 1;
    step(-2, "ng_pt");
    new_game = 0; point_right = 0;
    check("restart_left", int'(score_left), 0);
    check("restart_right", int'(score_right), 0);
    check("restart_over", int'(game_over), 0);
    point_right = 1;
    step(-2, "pt");
    check("after_restart_right", int'(score_right), 1);

    // Right wins 9-0
    for (int i = 0; i < 8; i++) step(-2, "pt");
    point_right = 0;
    check("rwin_right", int'(score_right), 9);
    check("rwin_over", int'(game_over), 1);
    check("rwin_winner", int'(winner), 1);

    // Blink: right digit flashes in 32-frame runs, left digit stays lit
    begin
      int dark_runs;
      dark_runs = 0;
      for (int f = 0; f < 64; f++) begin
        frame_tick = 1;
        set_pix(RIGHT_X0 + 14, Y0 + 5, 1);
        step(-1, "blink_right");
        frame_tick = 0;
        set_pix(LEFT_X0 + 14, Y0 + 5, 1);
        step(1, "steady_left");
        if (m_blink >= 32) dark_runs++;
      end
      check("blink_phase_count", dark_runs, 32);
    end
    set_pix(0, 0, 0);
    step(-2, "flush");
    step(-2, "flush");
    step(-2, "flush");
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
